led_mode_ctrl: RTL and testbench

//  Button front-end and mode/colour controller for the RGB LED demo top. Synchronises and

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_mode_ctrl_if.sv | 11 +
 rtl/led_mode_ctrl_debounce.sv | 44 ++++
 rtl/led_mode_ctrl.sv | 53 +++++
 tb/tb_led_mode_ctrl.sv | 135 +++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the RGB LED demo: working modes, one-hot colours and button roles.
package led_pkg;
  localparam logic       MODE_SR   = 1'b0;
  localparam logic       MODE_FS   = 1'b1;
  localparam logic [2:0] COLOR_OFF = 3'b000;
  localparam logic [2:0] COLOR_R   = 3'b001;
  localparam logic [2:0] COLOR_G   = 3'b010;
  localparam logic [2:0] COLOR_B   = 3'b100;
  localparam int         BTN_MODE  = 0;
  localparam int         BTN_R     = 1;
  localparam int         BTN_G     = 2;
  localparam int         BTN_B     = 3;

  // Colour request resolution: R beats G beats B; re-requesting the active colour turns it off.
  function automatic logic [2:0] next_color(input logic [2:0] cur, input logic r, g, b);
    logic [2:0] req;
    req = r ? COLOR_R : g ? COLOR_G : b ? COLOR_B : COLOR_OFF;
    if (req == COLOR_OFF) return cur;
    return (cur == req) ? COLOR_OFF : req;
  endfunction
endpackage

// File: rtl/led_mode_ctrl_if.sv
// Button inputs and mode/colour outputs of the LED controller, grouped as one bus.
interface led_mode_ctrl_if #(parameter int NB_BTN = 4);
  logic [NB_BTN-1:0] btn;
  logic [NB_BTN-1:0] btn_pulse;
  logic              mode;
  logic [2:0]        color;
  logic              restart;

  modport master (output btn, input btn_pulse, mode, color, restart);
  modport slave  (input btn, output btn_pulse, mode, color, restart);
endinterface

// File: rtl/led_mode_ctrl_debounce.sv
// One push-button: 2-flop synchroniser, stable-count debounce and rising-edge event.
module btn_debounce #(
  parameter int NB_DB_CNT       = 20,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic i_reset,
  input  logic btn_i,
  output logic pulse_o
);
  localparam logic [NB_DB_CNT-1:0] TERM = NB_DB_CNT'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  logic                 db_q, db_d, db_dly_q;
  logic [NB_DB_CNT-1:0] cnt_q, cnt_d;

  // Any return of the synchronised input to the accepted level restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == TERM) db_d  = sync2_q;
      else               cnt_d = cnt_q + NB_DB_CNT'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse_o = db_q & ~db_dly_q;
endmodule

// File: rtl/led_mode_ctrl.sv
// Button front-end plus mode/colour sequencer; restart pulses after any visible state change.
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter int NB_BTN          = 4,
  parameter int NB_DB_CNT       = 20,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clock,
  input  logic             i_reset,
  led_mode_ctrl_if.slave   bus
);
  logic [NB_BTN-1:0] pulse;
  logic              mode_q, mode_d;
  logic [2:0]        color_q, color_d;
  logic              restart_q, restart_d;

  for (genvar i = 0; i < NB_BTN; i++) begin : g_btn
    btn_debounce #(
      .NB_DB_CNT       (NB_DB_CNT),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clock   (clock),
      .i_reset (i_reset),
      .btn_i   (bus.btn[i]),
      .pulse_o (pulse[i])
    );
  end

  // Restart tracks value change, not event arrival.
  always_comb begin
    mode_d    = mode_q ^ pulse[BTN_MODE];
    color_d   = next_color(color_q, pulse[BTN_R], pulse[BTN_G], pulse[BTN_B]);
    restart_d = (mode_d != mode_q) || (color_d != color_q);
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      mode_q    <= MODE_SR;
      color_q   <= COLOR_OFF;
      restart_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      color_q   <= color_d;
      restart_q <= restart_d;
    end
  end

  assign bus.btn_pulse = pulse;
  assign bus.mode      = mode_q;
  assign bus.color     = color_q;
  assign bus.restart   = restart_q;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with a 4-cycle debounce window.
module tb_led_mode_ctrl;
  localparam int D = 4;

  logic clock = 1'b0;
  logic i_reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  led_mode_ctrl_if #(.NB_BTN(4)) bus ();

  led_mode_ctrl #(
    .NB_BTN          (4),
    .NB_DB_CNT       (3),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n edges; sampling/driving happens 1 time unit after each edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Press mask m, check event/outputs at the exact latency, hold extra cycles, release.
  task automatic press(input string tag, input logic [3:0] m, input int hold,
                       input logic exp_mode, input logic [2:0] exp_color, input logic exp_rst);
    logic [3:0] extra;
    bus.btn = m;
    step(D + 1);
    chk({tag, "_pulse_early"}, bus.btn_pulse, 4'b0000);
    step(1);
    chk({tag, "_pulse"}, bus.btn_pulse, m);
    step(1);
    chk({tag, "_pulse_once"}, bus.btn_pulse, 4'b0000);
    chk({tag, "_mode"}, bus.mode, exp_mode);
    chk({tag, "_color"}, bus.color, exp_color);
    chk({tag, "_restart"}, bus.restart, exp_rst);
    step(1);
    chk({tag, "_restart_off"}, bus.restart, 1'b0);
    extra = '0;
    for (int k = 0; k < hold; k++) begin
      step(1);
      extra |= bus.btn_pulse;
    end
    bus.btn = '0;
    for (int k = 0; k < D + 4; k++) begin
      step(1);
      extra |= bus.btn_pulse;
    end
    chk({tag, "_no_extra_pulse"}, extra, 4'b0000);
    chk({tag, "_color_kept"}, bus.color, exp_color);
  endtask

  initial begin
    logic       seen;
    logic [2:0] col0;
    bus.btn = '0;
    i_reset = 1'b1;

    // 1. reset state
    step(3);
    chk("rst_mode", bus.mode, 1'b0);
    chk("rst_color", bus.color, 3'b000);
    chk("rst_restart", bus.restart, 1'b0);
    chk("rst_pulse", bus.btn_pulse, 4'b0000);
    i_reset = 1'b0;
    step(2);

    // 2. hold R ~20 cycles: one event, colour R
    press("t2_r", 4'b0010, 14, 1'b0, 3'b001, 1'b1);

    // 3. 3-cycle glitch on G is rejected
    col0 = bus.color;
    bus.btn = 4'b0100;
    step(3);
    bus.btn = '0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      seen |= (|bus.btn_pulse) | bus.restart;
    end
    chk("t3_glitch_event", seen, 1'b0);
    chk("t3_glitch_color", bus.color, col0);

    // R again toggles off, then R+B together -> R wins
    press("t4_r_off", 4'b0010, 0, 1'b0, 3'b000, 1'b1);
    press("t4_rb", 4'b1010, 0, 1'b0, 3'b001, 1'b1);
    press("t4_r_off2", 4'b0010, 0, 1'b0, 3'b000, 1'b1);
    press("t4_b", 4'b1000, 0, 1'b0, 3'b100, 1'b1);

    // 5. mode held 50 cycles, then mode+G on the same edge
    press("t5_mode", 4'b0001, 45, 1'b1, 3'b100, 1'b1);
    press("t5_mode_g", 4'b0101, 0, 1'b0, 3'b010, 1'b1);

    // 6. reset mid-debounce, button held through reset
    bus.btn = 4'b0001;
    step(4);
    i_reset = 1'b1;
    step(1);
    i_reset = 1'b0;
    chk("t6_rst_pulse", bus.btn_pulse, 4'b0000);
    chk("t6_rst_mode", bus.mode, 1'b0);
    chk("t6_rst_color", bus.color, 3'b000);
    chk("t6_rst_restart", bus.restart, 1'b0);
    step(D + 1);
    chk("t6_pulse_early", bus.btn_pulse, 4'b0000);
    step(1);
    chk("t6_pulse", bus.btn_pulse, 4'b0001);
    chk("t6_mode_early", bus.mode, 1'b0);
    step(1);
    chk("t6_mode", bus.mode, 1'b1);
    chk("t6_restart", bus.restart, 1'b1);
    bus.btn = '0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
